// File: rtl/ad5781_feeder.sv
// Sample sequencer ahead of the AD5781 SPI writer: issues the control word after
// reset, then streams FIFO codes as DAC-register writes at a fixed sample rate.
module ad5781_feeder #(
  parameter int unsigned SysFreq    = 32'd100000000,
  parameter int unsigned SampleFreq = 32'd100000,
  parameter int unsigned MinGap     = 128,
  parameter logic [9:0]  CtrlBits   = 10'h012,
  parameter int unsigned FifoAw     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [17:0]       sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              enable,
  output logic [23:0]       writedata,
  output logic              write,
  output logic              init_done,
  output logic              underrun,
  output logic [FifoAw:0]   fifo_level
);

  localparam int unsigned Period = SysFreq / SampleFreq;
  localparam int unsigned TimerW = (Period > 1) ? $clog2(Period) : 1;
  localparam int unsigned GapW   = $clog2(MinGap + 1);
  localparam int unsigned Depth  = 1 << FifoAw;

  typedef enum logic [1:0] {INIT_WAIT, INIT_CTRL, RUN} state_t;

  state_t              state;
  logic [GapW-1:0]     gap_cnt;
  logic [TimerW-1:0]   timer;
  logic                pending;
  logic [17:0]         mem [Depth];
  logic [FifoAw-1:0]   wr_ptr;
  logic [FifoAw-1:0]   rd_ptr;

  logic fifo_empty;
  logic push;
  logic pop;
  logic tick;
  logic issue;

  // Pop is judged only against the registered level, so a sample pushed into an
  // empty FIFO waits at least one cycle before it can be issued.
  always_comb begin
    fifo_empty   = (fifo_level == '0);
    sample_ready = (fifo_level != (FifoAw+1)'(Depth));
    push         = sample_valid & sample_ready;
    tick         = (state == RUN) && enable && (timer == TimerW'(Period - 1));
    issue        = (state == RUN) && enable && (pending || tick) && (gap_cnt == '0);
    pop          = issue & ~fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  // The gap counter is reloaded with MinGap-1 at each write so the earliest
  // following write lands exactly MinGap cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT_WAIT;
      gap_cnt    <= GapW'(MinGap - 1);
      timer      <= '0;
      pending    <= 1'b0;
      writedata  <= '0;
      write      <= 1'b0;
      init_done  <= 1'b0;
      underrun   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      write    <= 1'b0;
      underrun <= 1'b0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

      case (state)
        INIT_WAIT: begin
          if (gap_cnt == '0) begin
            writedata <= {1'b0, 3'b010, 10'b0, CtrlBits};
            write     <= 1'b1;
            gap_cnt   <= GapW'(MinGap - 1);
            state     <= INIT_CTRL;
          end
        end
        INIT_CTRL: begin
          init_done <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          if (!enable || tick) timer <= '0;
          else                 timer <= timer + 1'b1;

          if (!enable) begin
            pending <= 1'b0;
          end else if (issue) begin
            pending <= 1'b0;
            if (!fifo_empty) begin
              writedata <= {1'b0, 3'b001, mem[rd_ptr], 2'b00};
              write     <= 1'b1;
              gap_cnt   <= GapW'(MinGap - 1);
            end else begin
              underrun  <= 1'b1;
            end
          end else if (tick) begin
            pending <= 1'b1;
          end
        end
        default: state <= INIT_WAIT;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_ad5781_feeder.sv
// Directed bench for ad5781_feeder: a default instance (P=1000) and a fast-tick
// instance (P=64) that exercises merged ticks under the MinGap spacing.
module tb_ad5781_feeder;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic        reset_n;
  logic [17:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        enable;
  logic [23:0] writedata;
  logic        write;
  logic        init_done;
  logic        underrun;
  logic [4:0]  fifo_level;

  logic        b_reset_n;
  logic [17:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic        b_enable;
  logic [23:0] b_writedata;
  logic        b_write;
  logic        b_init_done;
  logic        b_underrun;
  logic [4:0]  b_level;

  ad5781_feeder dut (
    .clk(clk), .reset_n(reset_n), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .enable(enable), .writedata(writedata), .write(write),
    .init_done(init_done), .underrun(underrun), .fifo_level(fifo_level)
  );

  ad5781_feeder #(.SampleFreq(32'd1562500)) dut_fast (
    .clk(clk), .reset_n(b_reset_n), .sample_data(b_data), .sample_valid(b_valid),
    .sample_ready(b_ready), .enable(b_enable), .writedata(b_writedata), .write(b_write),
    .init_done(b_init_done), .underrun(b_underrun), .fifo_level(b_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [17:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // which: 0 = dut.write, 1 = dut.underrun, 2 = dut_fast.write; side counts the
  // other pulse of the same instance seen while waiting. at_cyc = -1 on timeout.
  task automatic waitEvent(input int which, input int budget, output int at_cyc, output int side);
    logic ev;
    logic sd;
    at_cyc = -1;
    side   = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      ev = (which == 0) ? write : (which == 1) ? underrun : b_write;
      sd = (which == 0) ? underrun : (which == 1) ? write : b_underrun;
      if (ev) begin
        at_cyc = cyc;
        return;
      end
      if (sd) side++;
    end
  endtask

  initial begin
    int rel;
    int en;
    int at;
    int prev;
    int side;
    logic [17:0] d;

    reset_n = 1'b0; sample_data = '0; sample_valid = 1'b0; enable = 1'b0;
    b_reset_n = 1'b0; b_data = '0; b_valid = 1'b0; b_enable = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_writedata", 32'(writedata), 32'h0);
    checkOutput("rst_write", 32'(write), 32'h0);
    checkOutput("rst_init_done", 32'(init_done), 32'h0);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    checkOutput("rst_ready", 32'(sample_ready), 32'h1);

    // Control word lands on the 128th edge after release.
    @(negedge clk);
    reset_n = 1'b1;
    repeat (127) @(posedge clk);
    #1 checkOutput("ctrl_early", 32'(write), 32'h0);
    @(posedge clk);
    #1 checkOutput("ctrl_write", 32'(write), 32'h1);
    checkOutput("ctrl_data", 32'(writedata), 32'h200012);
    checkOutput("ctrl_init_pre", 32'(init_done), 32'h0);
    @(posedge clk);
    #1 checkOutput("ctrl_single", 32'(write), 32'h0);
    checkOutput("init_done", 32'(init_done), 32'h1);

    waitEvent(0, 300, at, side);
    checkOutput("idle_no_write", 32'(at), 32'hFFFF_FFFF);

    // Three samples at P=1000.
    applyStimulus(18'h3FFFF);
    applyStimulus(18'h00000);
    applyStimulus(18'h20000);
    checkOutput("level3", 32'(fifo_level), 32'd3);
    @(negedge clk);
    enable = 1'b1;
    en = cyc;
    waitEvent(0, 1100, at, side);
    checkOutput("w1_time", 32'(at - en), 32'd1000);
    checkOutput("w1_data", 32'(writedata), 32'h1FFFFC);
    prev = at;
    waitEvent(0, 1100, at, side);
    checkOutput("w2_space", 32'(at - prev), 32'd1000);
    checkOutput("w2_data", 32'(writedata), 32'h100000);
    prev = at;
    waitEvent(0, 1100, at, side);
    checkOutput("w3_space", 32'(at - prev), 32'd1000);
    checkOutput("w3_data", 32'(writedata), 32'h180000);
    checkOutput("w3_no_underrun", 32'(side), 32'd0);
    checkOutput("drained", 32'(fifo_level), 32'd0);
    prev = at;

    // Empty FIFO: one underrun per tick, no writes, writedata held.
    waitEvent(1, 1100, at, side);
    checkOutput("u1_time", 32'(at - prev), 32'd1000);
    checkOutput("u1_no_write", 32'(side), 32'd0);
    checkOutput("u1_data_held", 32'(writedata), 32'h180000);
    prev = at;
    @(negedge clk);
    checkOutput("u1_single", 32'(underrun), 32'h0);
    waitEvent(1, 1100, at, side);
    checkOutput("u2_space", 32'(at - prev), 32'd1000);
    checkOutput("u2_no_write", 32'(side), 32'd0);

    // Fill to full with valid held high; the 17th sample must be refused.
    @(negedge clk);
    enable = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      sample_data = 18'h10000 + 18'(i);
      @(negedge clk);
      if (i == 15) begin
        checkOutput("full_level", 32'(fifo_level), 32'd16);
        checkOutput("full_ready", 32'(sample_ready), 32'h0);
      end
    end
    sample_valid = 1'b0;
    checkOutput("full_hold", 32'(fifo_level), 32'd16);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waitEvent(0, 1100, at, side);
      d = 18'h10000 + 18'(i);
      checkOutput($sformatf("drain%0d", i), 32'(writedata), 32'({4'b0001, d, 2'b00}));
    end
    prev = at;
    waitEvent(1, 1100, at, side);
    checkOutput("no_17th_write", 32'(side), 32'd0);
    checkOutput("no_17th_time", 32'(at - prev), 32'd1000);

    // Reset mid-stream with a sample still queued.
    applyStimulus(18'h00001);
    applyStimulus(18'h00002);
    waitEvent(0, 1100, at, side);
    checkOutput("pre_rst_data", 32'(writedata), 32'h100004);
    @(negedge clk);
    reset_n = 1'b0;
    #1 checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_writedata", 32'(writedata), 32'h0);
    checkOutput("mid_rst_init", 32'(init_done), 32'h0);
    checkOutput("mid_rst_ready", 32'(sample_ready), 32'h1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    waitEvent(0, 200, at, side);
    checkOutput("reinit_time", 32'(at - rel), 32'd128);
    checkOutput("reinit_data", 32'(writedata), 32'h200012);

    // Fast instance: P=64 < MinGap, writes every 128 cycles in FIFO order.
    @(negedge clk);
    b_reset_n = 1'b1;
    b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_data = 18'h2A000 + 18'(i);
      @(negedge clk);
    end
    b_valid = 1'b0;
    checkOutput("fast_level", 32'(b_level), 32'd8);
    waitEvent(2, 200, at, side);
    checkOutput("fast_ctrl", 32'(b_writedata), 32'h200012);
    @(negedge clk);
    b_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prev = at;
      waitEvent(2, 300, at, side);
      d = 18'h2A000 + 18'(i);
      checkOutput($sformatf("fast_data%0d", i), 32'(b_writedata), 32'({4'b0001, d, 2'b00}));
      checkOutput($sformatf("fast_no_underrun%0d", i), 32'(side), 32'd0);
      if (i > 0) checkOutput($sformatf("fast_space%0d", i), 32'(at - prev), 32'd128);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
